// File: rtl/uart_word_tx.sv
// 8N1 UART transmitter that sends NUM_BYTES of a 32-bit word, LSB byte first.
// Optional even parity bit per byte when UART_TX_PARITY_EN is defined.
module uart_word_tx #(
  parameter int unsigned CLKS_PER_BIT = 234,
  parameter int unsigned NUM_BYTES    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] data,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT) + 1;
  localparam int unsigned BIT_W  = 3;
  localparam int unsigned BYTE_W = 2;

  if (CLKS_PER_BIT < 2 || NUM_BYTES < 1 || NUM_BYTES > 4) begin : g_param_check
    $error("uart_word_tx: illegal CLKS_PER_BIT or NUM_BYTES");
  end

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t              r_state, w_state_n;
  logic [BAUD_W-1:0]   r_baud, w_baud_n;
  logic [BIT_W-1:0]    r_bit, w_bit_n;
  logic [BYTE_W-1:0]   r_byte, w_byte_n;
  logic [DATA_W-1:0]   r_shift, w_shift_n;
  logic                r_tx, w_tx_n;
  logic                r_busy, w_busy_n;
  logic                r_done, w_done_n;
  logic                w_last_tick;
`ifdef UART_TX_PARITY_EN
  logic                r_par, w_par_n;
`endif

  assign w_last_tick = (r_baud == BAUD_W'(CLKS_PER_BIT - 1));

  // Next-state and next-output logic; tx/busy/done are registered from these.
  always_comb begin
    w_state_n = r_state;
    w_baud_n  = r_baud;
    w_bit_n   = r_bit;
    w_byte_n  = r_byte;
    w_shift_n = r_shift;
    w_tx_n    = r_tx;
    w_busy_n  = r_busy;
    w_done_n  = 1'b0;
`ifdef UART_TX_PARITY_EN
    w_par_n   = r_par;
`endif
    if (r_state != S_IDLE) begin
      w_baud_n = w_last_tick ? '0 : r_baud + BAUD_W'(1);
    end
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_n = S_START;
          w_shift_n = data;
          w_baud_n  = '0;
          w_bit_n   = '0;
          w_byte_n  = '0;
          w_tx_n    = 1'b0;
          w_busy_n  = 1'b1;
`ifdef UART_TX_PARITY_EN
          w_par_n   = ^data[7:0];
`endif
        end
      end
      S_START: begin
        if (w_last_tick) begin
          w_state_n = S_DATA;
          w_bit_n   = '0;
          w_tx_n    = r_shift[0];
        end
      end
      S_DATA: begin
        if (w_last_tick) begin
          w_shift_n = r_shift >> 1;
          if (r_bit == BIT_W'(7)) begin
`ifdef UART_TX_PARITY_EN
            w_state_n = S_PARITY;
            w_tx_n    = r_par;
`else
            w_state_n = S_STOP;
            w_tx_n    = 1'b1;
`endif
          end else begin
            w_bit_n = r_bit + BIT_W'(1);
            w_tx_n  = r_shift[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (w_last_tick) begin
          w_state_n = S_STOP;
          w_tx_n    = 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (w_last_tick) begin
          if (r_byte == BYTE_W'(NUM_BYTES - 1)) begin
            w_state_n = S_IDLE;
            w_tx_n    = 1'b1;
            w_busy_n  = 1'b0;
            w_done_n  = 1'b1;
          end else begin
            // Next byte already sits in the low 8 bits after eight shifts.
            w_state_n = S_START;
            w_byte_n  = r_byte + BYTE_W'(1);
            w_tx_n    = 1'b0;
`ifdef UART_TX_PARITY_EN
            w_par_n   = ^r_shift[7:0];
`endif
          end
        end
      end
      default: begin
        w_state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_byte  <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_n;
      r_baud  <= w_baud_n;
      r_bit   <= w_bit_n;
      r_byte  <= w_byte_n;
      r_shift <= w_shift_n;
      r_tx    <= w_tx_n;
      r_busy  <= w_busy_n;
      r_done  <= w_done_n;
`ifdef UART_TX_PARITY_EN
      r_par   <= w_par_n;
`endif
    end
  end

  assign tx   = r_tx;
  assign busy = r_busy;
  assign done = r_done;

endmodule
